// File: rtl/fast_field_decoder.sv
// fast_field_decoder: decodes a stream of stop-bit terminated integer fields
// (bit 7 = stop, bits 6:0 = payload, most-significant group first) carried
// in byte-packed beats. One beat is accepted per IDLE visit, and its bytes
// are then consumed one per cycle in SCAN. A field may span any number of
// beats.
//
// Optional feature macro: FAST_DEC_OVF_EN. When defined, overflow detection
// is built in. Overflow is flagged when a nonzero bit shifts out of acc[63],
// or when the length exceeds MAX_BYTES. An overflowed field reports an
// all-ones value. When the macro is undefined, the decoder returns the low
// 64 bits of the accumulation and field_overflow is tied to 0.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   din             beat data; byte k is din[8k+7:8k], and byte 0 is first
//   din_bytes       number of valid bytes in the beat, counted from byte 0
//   din_valid/ready beat handshake (ready is high exactly in IDLE)
//   field_value     decoded value
//   field_len       encoded byte count of the field, saturating at 15
//   field_overflow  field exceeded 64 bits or MAX_BYTES
//   field_valid/ready field handshake
module fast_field_decoder #(
   parameter int unsigned BEAT_W    = 64,
   parameter int unsigned MAX_BYTES = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BEAT_W-1:0] din,
   input  logic [3:0]        din_bytes,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [63:0]       field_value,
   output logic [3:0]        field_len,
   output logic              field_overflow,
   output logic              field_valid,
   input  logic              field_ready
);

   localparam int unsigned NB  = BEAT_W / 8;
   localparam int unsigned CAP = (NB < 8) ? NB : 8;
`ifdef FAST_DEC_OVF_EN
   localparam int unsigned ACC_W = 64;
`else
   // Bits above 56 are never observed once shifted, so they are not stored.
   localparam int unsigned ACC_W = 57;
`endif

   // Elaboration-time parameter sanity check.
   if ((BEAT_W % 8) != 0 || BEAT_W == 0 || MAX_BYTES == 0) begin : g_param_chk
      $error("fast_field_decoder: BEAT_W must be a nonzero multiple of 8 and MAX_BYTES nonzero");
   end

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [BEAT_W-1:0]  r_buf;
   logic [3:0]         r_byte_cnt;
   logic [3:0]         r_idx;
   logic [ACC_W-1:0]   r_acc;
   logic [3:0]         r_len;

   logic               w_accept;
   logic               w_consume;
   logic               w_last;
   logic [3:0]         w_cnt;
   logic [7:0]         w_byte;
   logic [63:0]        w_acc_nxt;
   logic [3:0]         w_len_nxt;

   // Clamp the byte count to what the beat can actually hold.
   assign w_cnt     = (din_bytes > 4'(CAP)) ? 4'(CAP) : din_bytes;
   // The buffer shifts down as bytes are consumed, so the current byte is always at the bottom.
   assign w_byte    = r_buf[7:0];
   assign w_last    = (r_idx == (r_byte_cnt - 4'd1));
   assign w_acc_nxt = {r_acc[56:0], w_byte[6:0]};
   assign w_len_nxt = (r_len == 4'hF) ? r_len : (r_len + 4'd1);

`ifdef FAST_DEC_OVF_EN
   logic r_ovf;
   logic w_ovf_nxt;
   // Sticky overflow: bits lost off the top, or too many bytes.
   assign w_ovf_nxt = r_ovf | (|r_acc[63:57]) | (32'(w_len_nxt) > MAX_BYTES);
`else
   assign field_overflow = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state, handshake and byte-consume strobes.
   always_comb begin
      w_state_nxt = r_state;
      din_ready   = 1'b0;
      w_accept    = 1'b0;
      w_consume   = 1'b0;
      case (r_state)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) begin
               w_accept = 1'b1;
               if (din_bytes != 4'd0) w_state_nxt = SCAN;
            end
         end
         SCAN: begin
            // A byte may only advance when the output slot is free or draining.
            w_consume = !field_valid || field_ready;
            if (w_consume && w_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Beat buffer, accumulator and field output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf       <= '0;
         r_byte_cnt  <= '0;
         r_idx       <= '0;
         r_acc       <= '0;
         r_len       <= '0;
         field_value <= '0;
         field_len   <= '0;
         field_valid <= 1'b0;
`ifdef FAST_DEC_OVF_EN
         r_ovf          <= 1'b0;
         field_overflow <= 1'b0;
`endif
      end else begin
         if (w_accept && din_bytes != 4'd0) begin
            r_buf      <= din;
            r_byte_cnt <= w_cnt;
            r_idx      <= '0;
         end
         if (w_consume) begin
            r_buf <= r_buf >> 8;
            r_idx <= r_idx + 4'd1;
            if (w_byte[7]) begin
               // Stop byte: publish the finished field and start a fresh one.
               field_len   <= w_len_nxt;
               field_valid <= 1'b1;
               r_acc       <= '0;
               r_len       <= '0;
`ifdef FAST_DEC_OVF_EN
               field_value    <= w_ovf_nxt ? '1 : w_acc_nxt;
               field_overflow <= w_ovf_nxt;
               r_ovf          <= 1'b0;
`else
               field_value    <= w_acc_nxt;
`endif
            end else begin
               r_acc <= ACC_W'(w_acc_nxt);
               r_len <= w_len_nxt;
`ifdef FAST_DEC_OVF_EN
               r_ovf <= w_ovf_nxt;
`endif
               if (field_ready) field_valid <= 1'b0;
            end
         end else if (field_valid && field_ready) begin
            field_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fast_field_decoder.sv
// Self-checking bench for fast_field_decoder: a table of beats with expected
// fields feeds a scoreboard queue. A monitor pops and compares each field as
// it is handed off. Hand-written sequences cover latency, backpressure and
// reset corner cases.
module tb_fast_field_decoder;

`ifdef FAST_DEC_OVF_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] din;
   logic [3:0]  din_bytes;
   logic        din_valid;
   logic        din_ready;
   logic [63:0] field_value;
   logic [3:0]  field_len;
   logic        field_overflow;
   logic        field_valid;
   logic        field_ready;

   fast_field_decoder #(.BEAT_W(64), .MAX_BYTES(10)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_bytes(din_bytes),
      .din_valid(din_valid), .din_ready(din_ready),
      .field_value(field_value), .field_len(field_len),
      .field_overflow(field_overflow), .field_valid(field_valid),
      .field_ready(field_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] v;
      logic [3:0]  l;
      logic        o;
   } exp_t;

   typedef struct packed {
      logic [63:0] din;
      logic [3:0]  nb;
      logic        has;
      exp_t        e;
   } vec_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && field_valid && field_ready) begin
            if (q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_field: got value %h len %0d", field_value, field_len);
            end else begin
               e = q.pop_front();
               chk("field_value", field_value, e.v);
               chk("field_len", 64'(field_len), 64'(e.l));
               chk("field_overflow", 64'(field_overflow), 64'(e.o));
            end
         end
      end
   endtask

   // Present one beat from just after a rising edge; it transfers on the next edge.
   task automatic drive_beat(input logic [63:0] d, input logic [3:0] nb);
      int t = 0;
      while (!din_ready && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (!din_ready) begin
         n_tests++; n_fail++;
         $display("FAIL din_ready_timeout: got 0 expected 1");
      end
      din = d; din_bytes = nb; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() != 0 || !din_ready) && t < 300) begin
         @(posedge clk); #1; t++;
      end
      if (q.size() != 0 || !din_ready) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
   endtask

   function automatic vec_t mk(input logic [63:0] d, input logic [3:0] nb, input logic has,
                               input logic [63:0] v, input logic [3:0] l, input logic o);
      vec_t r;
      r.din = d; r.nb = nb; r.has = has;
      r.e.v = v; r.e.l = l; r.e.o = o;
      return r;
   endfunction

   vec_t        vecs[12];
   logic [63:0] v8;
   logic [63:0] ovf_v;

   initial begin
      rst_n = 1'b0; din = '0; din_bytes = '0; din_valid = 1'b0; field_ready = 1'b1;

      v8 = (64'd1 << 49) | (64'd2 << 42) | (64'd3 << 35) | (64'd4 << 28) |
           (64'd5 << 21) | (64'd6 << 14) | (64'd7 << 7) | 64'd8;
      ovf_v = OVF ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
      vecs[0]  = mk(64'h8001,             4'd2, 1'b1, 64'd128,   4'd2,  1'b0);
      vecs[1]  = mk(64'h0201,             4'd2, 1'b0, 64'd0,     4'd0,  1'b0);
      vecs[2]  = mk(64'h83,               4'd1, 1'b1, 64'd16643, 4'd3,  1'b0);
      vecs[3]  = mk(64'hFF7F,             4'd2, 1'b1, 64'd16383, 4'd2,  1'b0);
      vecs[4]  = mk(64'h85,               4'd0, 1'b0, 64'd0,     4'd0,  1'b0);
      vecs[5]  = mk(64'h8807060504030201, 4'd8, 1'b1, v8,        4'd8,  1'b0);
      vecs[6]  = mk(64'h8000000000000001, 4'd9, 1'b1, 64'd1 << 49, 4'd8, 1'b0);
      vecs[7]  = mk(64'h01,               4'd8, 1'b0, 64'd0,     4'd0,  1'b0);
      vecs[8]  = mk(64'h800000,           4'd3, 1'b1, ovf_v,     4'd11, OVF);
      vecs[9]  = mk(64'h0,                4'd8, 1'b0, 64'd0,     4'd0,  1'b0);
      vecs[10] = mk(64'h0,                4'd8, 1'b0, 64'd0,     4'd0,  1'b0);
      vecs[11] = mk(64'h80,               4'd1, 1'b1, ovf_v,     4'd15, OVF);

      // Reset state, with din_valid held high to show nothing transfers.
      din_valid = 1'b1; din = 64'h85; din_bytes = 4'd1;
      #12;
      chk("rst_din_ready", 64'(din_ready), 64'd1);
      chk("rst_field_valid", 64'(field_valid), 64'd0);
      chk("rst_field_value", field_value, 64'd0);
      chk("rst_field_len", 64'(field_len), 64'd0);
      chk("rst_field_overflow", 64'(field_overflow), 64'd0);
      din_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      fork monitor(); join_none
      @(posedge clk); #1;

      // Latency: 0x85 accepted, then consumed, then field_valid for one cycle.
      q.push_back('{v: 64'd5, l: 4'd1, o: 1'b0});
      drive_beat(64'h85, 4'd1);
      @(negedge clk); chk("lat_valid_c1", 64'(field_valid), 64'd0);
      @(negedge clk); chk("lat_valid_c2", 64'(field_valid), 64'd1);
      @(negedge clk); chk("lat_valid_c3", 64'(field_valid), 64'd0);
      drain();

      // Table-driven vectors with an always-ready sink.
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].has) q.push_back(vecs[i].e);
         drive_beat(vecs[i].din, vecs[i].nb);
      end
      drain();

      // Backpressure: first field held, remaining bytes stall, then no loss.
      field_ready = 1'b0;
      q.push_back('{v: 64'd1, l: 4'd1, o: 1'b0});
      q.push_back('{v: 64'd2, l: 4'd1, o: 1'b0});
      q.push_back('{v: 64'd3, l: 4'd1, o: 1'b0});
      drive_beat(64'h838281, 4'd3);
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 64'(field_valid), 64'd1);
         chk("bp_value", field_value, 64'd1);
         chk("bp_stalled", 64'(din_ready), 64'd0);
      end
      @(posedge clk); #1; field_ready = 1'b1;
      drain();

      // Reset with a held field and a buffered beat.
      field_ready = 1'b0;
      q.push_back('{v: 64'd5, l: 4'd1, o: 1'b0});
      drive_beat(64'h85, 4'd1);
      @(posedge clk); #1;
      drive_beat(64'h0201, 4'd2);
      @(negedge clk); chk("rsta_pre_valid", 64'(field_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rsta_valid", 64'(field_valid), 64'd0);
      chk("rsta_din_ready", 64'(din_ready), 64'd1);
      chk("rsta_value", field_value, 64'd0);
      q.delete();
      @(negedge clk); rst_n = 1'b1; field_ready = 1'b1;
      @(posedge clk); #1;

      // Reset after two bytes of a field, then a fresh field decodes cleanly.
      drive_beat(64'h0201, 4'd2);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1 chk("rstb_valid", 64'(field_valid), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      q.push_back('{v: 64'd5, l: 4'd1, o: 1'b0});
      drive_beat(64'h85, 4'd1);
      drain();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fast_field_decoder.md
FAST_FIELD_DECODER -- requirements
Module: fast_field_decoder

Interface
REQ-001 SHALL have parameter BEAT_W, default 64, meaning input beat width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter MAX_BYTES, default 10, meaning the longest legal encoded field in bytes for a 64-bit value.
REQ-003 SHALL have clock `clk`, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have reset `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have `din`, input, BEAT_W bits: raw stream beat; byte k is din[8k+7:8k]; byte 0 is first on the wire.
REQ-006 SHALL have `din_bytes`, input, 4 bits: count of valid bytes in the beat, starting at byte 0.
REQ-007 SHALL have `din_valid`, input, 1 bit, and `din_ready`, output, 1 bit: the beat handshake.
REQ-008 SHALL have `field_value`, output, 64 bits: the decoded unsigned integer.
REQ-009 SHALL have `field_len`, output, 4 bits: encoded byte count of the field, saturating at 15.
REQ-010 SHALL have `field_overflow`, output, 1 bit: the field exceeded 64 bits or MAX_BYTES.
REQ-011 SHALL have `field_valid`, output, 1 bit, and `field_ready`, input, 1 bit: the field handshake.

Function
REQ-012 Byte format SHALL be: bit 7 = stop bit; bits 6:0 = payload, most-significant group first.
REQ-013 The FSM SHALL have states IDLE and SCAN, with din_ready = 1 exactly in IDLE.
- A beat transfers in IDLE when din_valid = 1.
- The beat is captured into an internal buffer, byte_cnt = min(din_bytes, 8), idx = 0, and the FSM goes to SCAN.
REQ-014 A beat with din_bytes = 0 SHALL be accepted and discarded, with the FSM staying in IDLE.
REQ-015 SCAN SHALL consume one byte per cycle, and only when field_valid = 0 or field_ready = 1; otherwise the byte stalls and all state holds.
REQ-016 Each consumed byte SHALL update the accumulator as acc <= (acc << 7) | payload, and len <= len + 1 (saturating).
REQ-017 When a consumed byte has its stop bit set:
- On the next edge, field_value/field_len/field_overflow load from the updated acc/len/ovf, and field_valid = 1.
- acc, len and ovf then clear.
REQ-018 After the byte at idx = byte_cnt - 1 is consumed, the FSM SHALL return to IDLE; otherwise idx increments.
REQ-019 acc, len and ovf SHALL persist across beats, so a field may span any number of beats.
REQ-020 field_valid SHALL fall on the edge where field_valid = 1, field_ready = 1 and no new stop byte is consumed.
- On simultaneous pop and stop byte, the new field replaces the old one and field_valid stays 1.
REQ-021 field_value, field_len and field_overflow SHALL stay stable while field_valid = 1 and field_ready = 0.
REQ-022 Latency SHALL be: the first byte of a beat is consumed on the cycle after acceptance; field_valid rises on the cycle after its stop byte is consumed.
REQ-023 Throughput SHALL be one byte per cycle within a beat, plus one IDLE cycle per beat.

Reset
REQ-024 On rst_n = 0 the block SHALL immediately clear the following, independent of clk:
- FSM to IDLE; idx, byte_cnt, acc, len, ovf to 0.
- field_valid, field_value, field_len and field_overflow to 0.
REQ-025 din_ready SHALL read 1 during reset, with no transfer occurring while rst_n = 0.
REQ-026 A reset mid-field SHALL discard the partial field and the buffered beat.

Configuration
REQ-027 Macro FAST_DEC_OVF_EN defined SHALL set ovf (sticky until field end) in either case below, and an overflowed field SHALL output field_value = 64'hFFFF_FFFF_FFFF_FFFF:
- any nonzero bit is shifted out of acc[63]; or
- len exceeds MAX_BYTES.
REQ-028 Without FAST_DEC_OVF_EN, field_value SHALL be the low 64 bits of the accumulation, field_overflow SHALL be constant 0, and no overflow logic SHALL be built.

Verification
REQ-029 din = 0x85 in byte 0, din_bytes = 1, field_ready = 1 -> field_value = 5, field_len = 1, field_valid for one cycle, 2 cycles after acceptance.
REQ-030 Bytes 0x01, 0x80 in one beat -> field_value = 128, field_len = 2.
REQ-031 Beat A = {0x01, 0x02} (din_bytes = 2), then beat B = {0x83} (din_bytes = 1) -> field_value = 16643, field_len = 3, a single field.
REQ-032 Beat {0x81, 0x82, 0x83} with field_ready = 0 for 5 cycles -> field_value = 1 held stable and no bytes consumed; after release, values 1, 2, 3 in order with no loss.
REQ-033 Bytes 0x01, nine 0x00, then 0x80 (11 bytes):
- FAST_DEC_OVF_EN defined -> field_overflow = 1, field_value = all ones, field_len = 11.
- Macro undefined -> field_overflow = 0, field_value = 0.
REQ-034 rst_n pulsed low after 2 bytes of a field -> field_valid = 0 immediately; the next field 0x85 then decodes to 5, field_len = 1.
